// File: rtl/debounce_fsm_if.sv
// -----------------------------------------------------------------------------
// debounce_fsm_if
//   Bundles the data-path signals of the multi-channel debouncer.
//   SYNC_IN     : synchronized raw inputs, driven by the producer (master)
//   DEB_OUT     : debounced levels, driven by the debouncer (slave)
//   RISE_PULSE  : one-cycle 0->1 strobes, driven by the debouncer
//   FALL_PULSE  : one-cycle 1->0 strobes, driven by the debouncer
//   Clock and reset are not part of the bundle; they are plain module ports.
// -----------------------------------------------------------------------------
interface debounce_fsm_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] SYNC_IN;
  logic [BUS_WIDTH-1:0] DEB_OUT;
  logic [BUS_WIDTH-1:0] RISE_PULSE;
  logic [BUS_WIDTH-1:0] FALL_PULSE;

  // Producer of the raw inputs / consumer of the debounced results.
  modport master (
    output SYNC_IN,
    input  DEB_OUT,
    input  RISE_PULSE,
    input  FALL_PULSE
  );

  // The debouncer itself.
  modport slave (
    input  SYNC_IN,
    output DEB_OUT,
    output RISE_PULSE,
    output FALL_PULSE
  );
endinterface

// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
//   Multi-channel switch debouncer placed after the bit synchronizer.
//   Each channel runs its own 4-state FSM (STABLE_LO, CHK_HI, STABLE_HI,
//   CHK_LO) and stability counter; a single shared prescaler generates the
//   sampling tick for all channels.
//
// Ports
//   CLK          : single clock, everything on posedge
//   RST          : synchronous, active-high reset (highest priority)
//   bus.SYNC_IN  : synchronized raw inputs (may bounce)
//   bus.DEB_OUT  : registered debounced levels
//   bus.RISE_PULSE / bus.FALL_PULSE : registered one-cycle edge strobes,
//                  coincident with the first cycle of the new DEB_OUT level
//
// Parameters
//   BUS_WIDTH    : number of independent channels (>=1)
//   TICK_DIV     : clock cycles per sampling tick (>=1, 1 = every cycle)
//   STABLE_TICKS : ticks a new level must persist before DEB_OUT follows (>=1)
// -----------------------------------------------------------------------------
module debounce_fsm #(
  parameter int BUS_WIDTH    = 8,
  parameter int TICK_DIV     = 1,
  parameter int STABLE_TICKS = 4
) (
  input  logic            CLK,
  input  logic            RST,
  debounce_fsm_if.slave   bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Shared prescaler. With TICK_DIV=1 the counter stays at 0 and the tick is
  // permanently asserted.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel FSMs
  // ---------------------------------------------------------------------------
  logic [BUS_WIDTH-1:0] deb_vec;
  logic [BUS_WIDTH-1:0] rise_vec;
  logic [BUS_WIDTH-1:0] fall_vec;

  generate
    for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_chan
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          deb_q, deb_d;
      logic          rise_q, rise_d;
      logic          fall_q, fall_d;
      logic          in_bit;

      assign in_bit = bus.SYNC_IN[gi];

      // The input-level check is tested before tick completion, so a bounce
      // on the final tick edge aborts the change. Entry into CHK_* always
      // clears the counter, so a tick on the entry edge is never counted.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
          STABLE_LO: begin
            if (in_bit) begin
              state_d = CHK_HI;
              cnt_d   = '0;
            end
          end
          CHK_HI: begin
            if (!in_bit) begin
              state_d = STABLE_LO;
              cnt_d   = '0;
            end else if (tick) begin
              if (cnt_q == CNT_LAST) begin
                state_d = STABLE_HI;
                cnt_d   = '0;
                deb_d   = 1'b1;
                rise_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          STABLE_HI: begin
            if (!in_bit) begin
              state_d = CHK_LO;
              cnt_d   = '0;
            end
          end
          CHK_LO: begin
            if (in_bit) begin
              state_d = STABLE_HI;
              cnt_d   = '0;
            end else if (tick) begin
              if (cnt_q == CNT_LAST) begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                deb_d   = 1'b0;
                fall_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          deb_q   <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          deb_q   <= deb_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
        end
      end

      assign deb_vec[gi]  = deb_q;
      assign rise_vec[gi] = rise_q;
      assign fall_vec[gi] = fall_q;
    end
  endgenerate

  assign bus.DEB_OUT    = deb_vec;
  assign bus.RISE_PULSE = rise_vec;
  assign bus.FALL_PULSE = fall_vec;

endmodule

// File: tb/tb_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_debounce_fsm
//   Two instances: dut_a (BUS_WIDTH=2, TICK_DIV=1, STABLE_TICKS=4) and
//   dut_b (BUS_WIDTH=2, TICK_DIV=3, STABLE_TICKS=2). Stimulus is applied on
//   the falling edge; for every applied cycle the hand-computed expected
//   {DEB_OUT, RISE_PULSE, FALL_PULSE} after the next rising edge is pushed
//   into a per-DUT queue. A monitor pops and compares 1 ns after each rising
//   edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_fsm;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  debounce_fsm_if #(.BUS_WIDTH(2)) if_a ();
  debounce_fsm_if #(.BUS_WIDTH(2)) if_b ();

  debounce_fsm #(.BUS_WIDTH(2), .TICK_DIV(1), .STABLE_TICKS(4)) dut_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (if_a)
  );

  debounce_fsm #(.BUS_WIDTH(2), .TICK_DIV(3), .STABLE_TICKS(2)) dut_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (if_b)
  );

  typedef struct {
    logic [5:0] exp;   // {deb[1:0], rise[1:0], fall[1:0]}
    string      tag;
  } txn_t;

  txn_t q_a[$];
  txn_t q_b[$];

  int checks = 0;
  int errors = 0;

  // Apply n identical cycles to one DUT, queueing the expected outputs.
  task automatic cyc(input bit sel, input int n, input logic r, input logic [1:0] s,
                     input logic [1:0] d, input logic [1:0] rs, input logic [1:0] fl,
                     input string tag);
    txn_t t;
    for (int k = 0; k < n; k++) begin
      t.exp = {d, rs, fl};
      t.tag = tag;
      if (sel == 1'b0) begin
        rst_a        = r;
        if_a.SYNC_IN = s;
        q_a.push_back(t);
      end else begin
        rst_b        = r;
        if_b.SYNC_IN = s;
        q_b.push_back(t);
      end
      @(negedge clk);
    end
  endtask

  // Monitor: one comparison per queued transaction.
  always @(posedge clk) begin
    txn_t       t;
    logic [5:0] got;
    #1;
    if (q_a.size() > 0) begin
      t   = q_a.pop_front();
      got = {if_a.DEB_OUT, if_a.RISE_PULSE, if_a.FALL_PULSE};
      checks++;
      if (got !== t.exp) begin
        errors++;
        $display("FAIL A %s: got deb=%b rise=%b fall=%b, expected deb=%b rise=%b fall=%b",
                 t.tag, got[5:4], got[3:2], got[1:0], t.exp[5:4], t.exp[3:2], t.exp[1:0]);
      end else begin
        $display("ok   A %s: deb=%b rise=%b fall=%b", t.tag, got[5:4], got[3:2], got[1:0]);
      end
    end
    if (q_b.size() > 0) begin
      t   = q_b.pop_front();
      got = {if_b.DEB_OUT, if_b.RISE_PULSE, if_b.FALL_PULSE};
      checks++;
      if (got !== t.exp) begin
        errors++;
        $display("FAIL B %s: got deb=%b rise=%b fall=%b, expected deb=%b rise=%b fall=%b",
                 t.tag, got[5:4], got[3:2], got[1:0], t.exp[5:4], t.exp[3:2], t.exp[1:0]);
      end else begin
        $display("ok   B %s: deb=%b rise=%b fall=%b", t.tag, got[5:4], got[3:2], got[1:0]);
      end
    end
  end

  initial begin
    int pending;
    if_a.SYNC_IN = 2'b00;
    if_b.SYNC_IN = 2'b00;
    @(negedge clk);

    // ---- DUT A: TICK_DIV=1, STABLE_TICKS=4 --------------------------------
    // Reset held with inputs high: outputs stay 0.
    cyc(0, 3, 1, 2'b11, 2'b00, 2'b00, 2'b00, "reset_hold");
    // Release: CHK_HI entered on edge 1, rise on edge 5.
    cyc(0, 4, 0, 2'b11, 2'b00, 2'b00, 2'b00, "post_reset_wait");
    cyc(0, 1, 0, 2'b11, 2'b11, 2'b11, 2'b00, "post_reset_rise");
    cyc(0, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, "post_reset_hold");
    // Both fall together.
    cyc(0, 4, 0, 2'b00, 2'b11, 2'b00, 2'b00, "fall_wait");
    cyc(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b11, "fall_both");
    cyc(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "fall_hold");
    // Clean step on bit0 only.
    cyc(0, 4, 0, 2'b01, 2'b00, 2'b00, 2'b00, "step0_wait");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b01, 2'b00, "step0_rise");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, "step0_hold");
    cyc(0, 4, 0, 2'b00, 2'b01, 2'b00, 2'b00, "step0_fall_wait");
    cyc(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, "step0_fall");
    cyc(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "step0_fall_hold");
    // Bounce 1,1,1,0,1,1,1,1,1 on bit0: re-entry at sample 5, rise at sample 9.
    cyc(0, 3, 0, 2'b01, 2'b00, 2'b00, 2'b00, "bounce_pre");
    cyc(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_low");
    cyc(0, 4, 0, 2'b01, 2'b00, 2'b00, 2'b00, "bounce_recheck");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b01, 2'b00, "bounce_rise");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, "bounce_hold");
    // Bit1 high for 4 edges then low on the completing edge: no rise.
    cyc(0, 4, 0, 2'b11, 2'b01, 2'b00, 2'b00, "lasttick_hi");
    cyc(0, 3, 0, 2'b01, 2'b01, 2'b00, 2'b00, "lasttick_abort_rise");
    // Mirror on bit0 from STABLE_HI: no fall.
    cyc(0, 4, 0, 2'b00, 2'b01, 2'b00, 2'b00, "lasttick_lo");
    cyc(0, 3, 0, 2'b01, 2'b01, 2'b00, 2'b00, "lasttick_abort_fall");
    // Bring bit1 high, then start its fall and reset at cnt=2.
    cyc(0, 4, 0, 2'b11, 2'b01, 2'b00, 2'b00, "b1_rise_wait");
    cyc(0, 1, 0, 2'b11, 2'b11, 2'b10, 2'b00, "b1_rise");
    cyc(0, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, "b1_hold");
    cyc(0, 3, 0, 2'b01, 2'b11, 2'b00, 2'b00, "b1_chk_lo");
    cyc(0, 1, 1, 2'b01, 2'b00, 2'b00, 2'b00, "reset_mid_check");
    // After reset bit1 sits in STABLE_LO (low input: nothing happens),
    // bit0 goes through a fresh rise.
    cyc(0, 4, 0, 2'b01, 2'b00, 2'b00, 2'b00, "after_reset_wait");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b01, 2'b00, "after_reset_rise");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, "after_reset_hold");
    // Simultaneous opposite transitions on the two channels.
    cyc(0, 4, 0, 2'b10, 2'b01, 2'b00, 2'b00, "swap1_wait");
    cyc(0, 1, 0, 2'b10, 2'b10, 2'b10, 2'b01, "swap1_edge");
    cyc(0, 1, 0, 2'b10, 2'b10, 2'b00, 2'b00, "swap1_hold");
    cyc(0, 4, 0, 2'b01, 2'b10, 2'b00, 2'b00, "swap2_wait");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b01, 2'b10, "swap2_edge");
    cyc(0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, "swap2_hold");

    // ---- DUT B: TICK_DIV=3, STABLE_TICKS=2 --------------------------------
    // Ticks fall on edges 3, 6, 9, ... after reset release.
    cyc(1, 2, 1, 2'b00, 2'b00, 2'b00, 2'b00, "psc_reset");
    cyc(1, 5, 0, 2'b01, 2'b00, 2'b00, 2'b00, "psc_rise_wait");   // edges 1-5
    cyc(1, 1, 0, 2'b01, 2'b01, 2'b01, 2'b00, "psc_rise");        // edge 6
    cyc(1, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, "psc_rise_hold");   // edge 7
    cyc(1, 4, 0, 2'b00, 2'b01, 2'b00, 2'b00, "psc_fall_wait");   // edges 8-11
    cyc(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, "psc_fall");        // edge 12
    cyc(1, 2, 0, 2'b00, 2'b00, 2'b00, 2'b00, "psc_fall_hold");   // edges 13-14
    // Entry on tick edge 15 is not counted: ticks at 18, 21 -> rise at 21.
    cyc(1, 6, 0, 2'b11, 2'b00, 2'b00, 2'b00, "psc_entry_tick");  // edges 15-20
    cyc(1, 1, 0, 2'b11, 2'b11, 2'b11, 2'b00, "psc_rise2");       // edge 21
    cyc(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, "psc_rise2_hold");  // edge 22

    repeat (3) @(negedge clk);

    // Every queued expectation must have been consumed by the monitor.
    pending = q_a.size() + q_b.size();
    checks++;
    if (pending != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", pending);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
